linked_list_wr_ctrl: RTL and testbench

- Write controller sitting directly upstream of linked_list_data_mem.
- Appends pushed data words to the tail of a singly linked list: allocates a free node, writes the payload into the data memory, waits for wr_done, then links the node.
- Owns the free-node bitmap and next-pointer array.
- Exposes head/count/next-pointer to the read controller; accepts head pops from it.

---
 rtl/linked_list_wr_ctrl.sv | 133 +++++++++++++
 tb/tb_linked_list_wr_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/linked_list_wr_ctrl.sv
// Write controller for a singly linked list: allocates a free node, writes the payload to
// linked_list_data_mem, links it at the tail. Optional write timeout: LINKED_LIST_WR_TIMEOUT_EN.
module linked_list_wr_ctrl #(
  parameter int WR_ADDR_WD = 4,
  parameter int WR_DATA_WD = 32,
  parameter int DATA_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_vld,
  input  logic [WR_DATA_WD-1:0] push_data,
  output logic                  push_rdy,
  output logic                  push_done,
  input  logic                  pop_vld,
  output logic                  pop_rdy,
  output logic [WR_ADDR_WD-1:0] head_ptr,
  output logic [WR_ADDR_WD-1:0] tail_ptr,
  output logic [WR_ADDR_WD:0]   list_cnt,
  output logic                  empty,
  output logic                  full,
  input  logic [WR_ADDR_WD-1:0] nxt_rd_addr,
  output logic [WR_ADDR_WD-1:0] nxt_rd_ptr,
  output logic                  wr_vld,
  output logic [WR_ADDR_WD-1:0] wr_addr,
  output logic [WR_DATA_WD-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_err
);

  typedef enum logic [1:0] {IDLE, WR, WAIT, LINK} state_t;

  state_t                  state;
  logic [DATA_DEPTH-1:0]   free_map;
  logic [WR_ADDR_WD-1:0]   nxt_ptr [DATA_DEPTH];
  logic [WR_ADDR_WD-1:0]   node;
  logic [WR_ADDR_WD-1:0]   alloc;
  logic                    push_acc;
  logic                    pop_acc;
`ifdef LINKED_LIST_WR_TIMEOUT_EN
  logic [3:0]              wait_cnt;
`endif

  function automatic logic [WR_ADDR_WD-1:0] lowest_free(input logic [DATA_DEPTH-1:0] map);
    lowest_free = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (map[i]) lowest_free = WR_ADDR_WD'(i);
    end
  endfunction

  assign alloc      = lowest_free(free_map);
  assign full       = ~|free_map;
  assign empty      = (list_cnt == '0);
  assign push_rdy   = (state == IDLE) && !full;
  assign pop_rdy    = !empty && (state != LINK);
  assign push_acc   = push_vld && push_rdy;
  assign pop_acc    = pop_vld && pop_rdy;
  assign nxt_rd_ptr = nxt_ptr[nxt_rd_addr];

`ifndef LINKED_LIST_WR_TIMEOUT_EN
  assign wr_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= IDLE;
      head_ptr  <= '0;
      tail_ptr  <= '0;
      list_cnt  <= '0;
      free_map  <= '1;
      for (int i = 0; i < DATA_DEPTH; i++) nxt_ptr[i] <= '0;
      node      <= '0;
      wr_vld    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      push_done <= 1'b0;
`ifdef LINKED_LIST_WR_TIMEOUT_EN
      wait_cnt  <= '0;
      wr_err    <= 1'b0;
`endif
    end else begin
      wr_vld    <= 1'b0;
      push_done <= 1'b0;
      case (state)
        IDLE: begin
          if (push_acc) begin
            node            <= alloc;
            free_map[alloc] <= 1'b0;
            wr_vld          <= 1'b1;
            wr_addr         <= alloc;
            wr_data         <= push_data;
            state           <= WR;
          end
        end
        WR: begin
          state <= WAIT;
`ifdef LINKED_LIST_WR_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (wr_done) begin
            push_done <= 1'b1;
            state     <= LINK;
          end
`ifdef LINKED_LIST_WR_TIMEOUT_EN
          // Give up after 15 silent WAIT cycles and hand the node back.
          else if (wait_cnt == 4'd14) begin
            wr_err         <= 1'b1;
            free_map[node] <= 1'b1;
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end
        default: begin
          if (list_cnt == '0) head_ptr <= node;
          else nxt_ptr[tail_ptr] <= node;
          tail_ptr <= node;
          list_cnt <= list_cnt + 1'b1;
          state    <= IDLE;
        end
      endcase
      // Pops never coincide with LINK, so list_cnt has a single writer per cycle.
      if (pop_acc) begin
        free_map[head_ptr] <= 1'b1;
        if (list_cnt != 1) head_ptr <= nxt_ptr[head_ptr];
        list_cnt <= list_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_linked_list_wr_ctrl.sv
// Bench for linked_list_wr_ctrl: directed scenarios plus random traffic checked every cycle
// against a queue-based model of the list, free set and next pointers.
module tb_linked_list_wr_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          push_vld = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          push_rdy, push_done;
  logic          pop_vld = 1'b0;
  logic          pop_rdy;
  logic [AW-1:0] head_ptr, tail_ptr;
  logic [AW:0]   list_cnt;
  logic          empty, full;
  logic [AW-1:0] nxt_rd_addr = '0;
  logic [AW-1:0] nxt_rd_ptr;
  logic          wr_vld;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_done = 1'b0;
  logic          wr_err;

  linked_list_wr_ctrl #(.WR_ADDR_WD(AW), .WR_DATA_WD(DW), .DATA_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .push_vld(push_vld), .push_data(push_data),
    .push_rdy(push_rdy), .push_done(push_done), .pop_vld(pop_vld), .pop_rdy(pop_rdy),
    .head_ptr(head_ptr), .tail_ptr(tail_ptr), .list_cnt(list_cnt), .empty(empty),
    .full(full), .nxt_rd_addr(nxt_rd_addr), .nxt_rd_ptr(nxt_rd_ptr), .wr_vld(wr_vld),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: list contents as a queue of node indices, in-flight push tracked by phase
  // (0 idle, 1 write strobe, 2 waiting for ack, 3 linking).
  bit            m_free [D];
  int            m_nxt  [D];
  int            m_lst  [$];
  int            m_head, m_tail, m_phase, m_node, m_wait;
  logic [DW-1:0] m_payload;
  bit            m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < D; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_free[i] = 1'b1;
      m_nxt[i]  = 0;
    end
    m_lst.delete();
    m_head = 0; m_tail = 0; m_phase = 0; m_node = 0; m_wait = 0;
    m_payload = '0; m_err = 1'b0;
  endtask

  task automatic compare_all();
    bit anyfree;
    anyfree = (lowest_free() >= 0);
    chk("push_rdy", push_rdy, (m_phase == 0) && anyfree);
    chk("pop_rdy", pop_rdy, (m_lst.size() > 0) && (m_phase != 3));
    chk("push_done", push_done, m_phase == 3);
    chk("wr_vld", wr_vld, m_phase == 1);
    if (m_phase == 1) begin
      chk("wr_addr", wr_addr, m_node);
      chk("wr_data", wr_data, m_payload);
    end
    chk("head_ptr", head_ptr, m_head);
    chk("tail_ptr", tail_ptr, m_tail);
    chk("list_cnt", list_cnt, m_lst.size());
    chk("empty", empty, m_lst.size() == 0);
    chk("full", full, !anyfree);
    chk("nxt_rd_ptr", nxt_rd_ptr, m_nxt[nxt_rd_addr]);
    chk("wr_err", wr_err, m_err);
  endtask

  task automatic model_step();
    bit pop_acc, push_acc;
    int n;
    pop_acc  = pop_vld && (m_lst.size() > 0) && (m_phase != 3);
    push_acc = push_vld && (m_phase == 0) && (lowest_free() >= 0);
    case (m_phase)
      0: if (push_acc) begin
        n = lowest_free();
        m_free[n] = 1'b0;
        m_node = n;
        m_payload = push_data;
        m_phase = 1;
      end
      1: begin m_phase = 2; m_wait = 0; end
      2: if (wr_done) m_phase = 3;
         else begin
           m_wait++;
`ifdef LINKED_LIST_WR_TIMEOUT_EN
           if (m_wait == 15) begin
             m_err = 1'b1;
             m_free[m_node] = 1'b1;
             m_phase = 0;
           end
`endif
         end
      default: begin
        if (m_lst.size() == 0) m_head = m_node;
        else m_nxt[m_lst[m_lst.size()-1]] = m_node;
        m_lst.push_back(m_node);
        m_tail = m_node;
        m_phase = 0;
      end
    endcase
    if (pop_acc) begin
      n = m_lst.pop_front();
      m_free[n] = 1'b1;
      if (m_lst.size() > 0) m_head = m_lst[0];
    end
  endtask

  task automatic cyc(input bit pv, input logic [DW-1:0] pd, input bit popv,
                     input logic [AW-1:0] nra, input bit wd);
    @(posedge clk); #1;
    push_vld = pv; push_data = pd; pop_vld = popv; nxt_rd_addr = nra; wr_done = wd;
    @(negedge clk);
    compare_all();
    model_step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_vld = 1'b0; pop_vld = 1'b0; wr_done = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(posedge clk); #1;
    reset_n = 1'b0;
  endtask

  task automatic push_w(input logic [DW-1:0] d);
    cyc(1'b1, d, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bit wd;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_head", head_ptr, 0);
    chk("rst_cnt", list_cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_wr_vld", wr_vld, 0);
    chk("rst_push_rdy", push_rdy, 1);

    // Single push with prompt ack
    cyc(1'b1, 32'hA5A5_0001, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("t1_wr_vld", wr_vld, 1);
    chk("t1_wr_addr", wr_addr, 0);
    chk("t1_wr_data", wr_data, 32'hA5A5_0001);
    chk("t1_push_rdy", push_rdy, 0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t2_push_done", push_done, 0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("t3_push_done", push_done, 1);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("t4_head", head_ptr, 0);
    chk("t4_tail", tail_ptr, 0);
    chk("t4_cnt", list_cnt, 1);

    // Three pushes, then traversal
    do_reset();
    push_w(32'h11); push_w(32'h22); push_w(32'h33);
    cyc(1'b0, '0, 1'b0, 4'd1, 1'b0);
    chk("three_nxt1", nxt_rd_ptr, 2);
    chk("three_tail", tail_ptr, 2);
    cyc(1'b0, '0, 1'b0, 4'd0, 1'b0);
    chk("three_nxt0", nxt_rd_ptr, 1);

    // Fill, pop once, re-push into freed node 0
    for (int i = 3; i < D; i++) push_w(32'h100 + i);
    cyc(1'b0, '0, 1'b0, 4'd14, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_push_rdy", push_rdy, 0);
    chk("fill_cnt", list_cnt, 16);
    chk("fill_nxt14", nxt_rd_ptr, 15);
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("pop_head", head_ptr, 1);
    chk("pop_full", full, 0);
    cyc(1'b1, 32'hBEEF, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("refill_addr", wr_addr, 0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, 4'd15, 1'b0);
    chk("refill_tail", tail_ptr, 0);
    chk("refill_nxt15", nxt_rd_ptr, 0);
    chk("refill_cnt", list_cnt, 16);

    // Pop during WAIT empties the list; LINK then restarts it
    do_reset();
    push_w(32'hAAAA);
    cyc(1'b1, 32'hBBBB, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("wpop_head", head_ptr, 1);
    chk("wpop_tail", tail_ptr, 1);
    chk("wpop_cnt", list_cnt, 1);

    // Same-cycle push and pop with two nodes listed
    push_w(32'hCCCC);
    cyc(1'b1, 32'hDDDD, 1'b1, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("pp_alloc", wr_addr, 2);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("pp_cnt", list_cnt, 2);
    chk("pp_head", head_ptr, 0);
    cyc(1'b1, 32'hEEEE, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("pp_reuse", wr_addr, 1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);

`ifdef LINKED_LIST_WR_TIMEOUT_EN
    cyc(1'b1, 32'hDEAD, 1'b0, '0, 1'b0);
    repeat (16) cyc(1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("to_err", wr_err, 1);
    chk("to_cnt", list_cnt, 3);
    chk("to_push_rdy", push_rdy, 1);
`endif

    // Random traffic, with one mid-operation reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1200) do_reset();
      if (m_phase == 2) wd = ($urandom % 2 == 1) || (m_wait >= 4);
      else wd = ($urandom % 4 == 0);
      cyc($urandom % 2 == 1, $urandom, (c < 1500) ? ($urandom % 8 == 0) : ($urandom % 2 == 0),
          AW'($urandom % D), wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
